// File: rtl/conv_pkg.sv
// Shared constants and elaboration helpers for the programmable 3x3 convolution engine.
// Mode encodings, sharpen default coefficients, accumulator sizing and rounding bias.
package conv_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_CLAMP  = 2'b01;
    localparam logic [1:0] MODE_ABS    = 2'b10;

    localparam int COEF_CENTRE = 4;
    localparam int COEF_EDGE   = 2;
    localparam int COEF_CORNER = -1;

    // Headroom of 4 bits covers nine full-scale products of max-magnitude weight.
    function automatic int acc_width(input int dw, input int ww);
        return dw + ww + 4;
    endfunction

    function automatic int def_coef(input int k);
        if (k == 4)
            return COEF_CENTRE;
        else if ((k % 2) == 1)
            return COEF_EDGE;
        else
            return COEF_CORNER;
    endfunction

    function automatic int round_bias(input int sh);
        return (sh > 0) ? (1 << (sh - 1)) : 0;
    endfunction

endpackage

// File: rtl/conv_round_sat.sv
// Signed window sum -> round-half-up shift -> clamp / abs / bypass to a DW-bit pixel.
// Latency: combinational. Backpressure: none, evaluated inside the S3 register stage.
// Reserved mode 11 falls into the clamp branch.
module conv_round_sat
    import conv_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 17,
    parameter int SHIFT = 3
) (
    input  logic signed [AW-1:0] sum,
    input  logic        [DW-1:0] centre,
    input  logic        [1:0]    mode,
    output logic        [DW-1:0] res,
    output logic                 sat
);

    localparam logic signed [AW-1:0] RND  = AW'(round_bias(SHIFT));
    localparam logic signed [AW-1:0] PMAX = AW'((1 << DW) - 1);

    logic signed [AW-1:0] shifted;
    logic signed [AW-1:0] mag;

    always_comb begin
        shifted = (sum + RND) >>> SHIFT;
        mag     = shifted[AW-1] ? -shifted : shifted;
        res     = '0;
        sat     = 1'b0;
        case (mode)
            MODE_BYPASS: res = centre;
            MODE_ABS: begin
                if (mag > PMAX) begin
                    res = '1;
                    sat = 1'b1;
                end else begin
                    res = mag[DW-1:0];
                end
            end
            default: begin
                if (shifted[AW-1]) begin
                    res = '0;
                    sat = 1'b1;
                end else if (shifted > PMAX) begin
                    res = '1;
                    sat = 1'b1;
                end else begin
                    res = shifted[DW-1:0];
                end
            end
        endcase
    end

endmodule

// File: rtl/conv3x3_prog.sv
// Programmable 3x3 convolution with shadowed coefficients committed on start-of-frame.
// Latency: 3 enabled cycles in_valid -> out_valid. Backpressure: clken=0 freezes all stages.
// Bubbles propagate with out_valid=0 while out/sat_flag hold the last beat.
module conv3x3_prog
    import conv_pkg::*;
#(
    parameter int DW    = 8,
    parameter int WW    = 5,
    parameter int SHIFT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clken,
    input  logic                sof,
    input  logic                in_valid,
    input  logic [9*DW-1:0]     pix_win,
    input  logic                cfg_wr,
    input  logic [9*WW-1:0]     cfg_coef,
    input  logic [1:0]          cfg_mode,
    output logic [DW-1:0]       out,
    output logic                out_valid,
    output logic                sat_flag
);

    localparam int AW = acc_width(DW, WW);
    localparam int PW = DW + WW + 1;

    logic signed [WW-1:0] shadow_q [9];
    logic signed [WW-1:0] active_q [9];
    logic signed [WW-1:0] coef_nxt [9];
    logic signed [WW-1:0] coef_eff [9];
    logic [1:0]           mode_shadow_q, mode_active_q, mode_nxt, mode_eff;
    logic                 commit;

    logic signed [PW-1:0] prod_d [9];
    logic signed [PW-1:0] prod_q [9];
    logic [DW-1:0]        ctr1_q, ctr2_q;
    logic [1:0]           mode1_q, mode2_q;
    logic                 v1_q, v2_q;
    logic signed [AW-1:0] row_d [3];
    logic signed [AW-1:0] row_q [3];
    logic signed [AW-1:0] sum;
    logic [DW-1:0]        res_d;
    logic                 sat_d;

    assign commit = clken & sof;

    // A window arriving with sof already uses the coefficients being committed.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            coef_nxt[k] = cfg_wr ? cfg_coef[k*WW +: WW] : shadow_q[k];
            coef_eff[k] = commit ? coef_nxt[k] : active_q[k];
        end
        mode_nxt = cfg_wr ? cfg_mode : mode_shadow_q;
        mode_eff = commit ? mode_nxt : mode_active_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                shadow_q[k] <= WW'(def_coef(k));
                active_q[k] <= WW'(def_coef(k));
            end
            mode_shadow_q <= MODE_CLAMP;
            mode_active_q <= MODE_CLAMP;
        end else begin
            if (cfg_wr) begin
                for (int k = 0; k < 9; k++)
                    shadow_q[k] <= cfg_coef[k*WW +: WW];
                mode_shadow_q <= cfg_mode;
            end
            if (commit) begin
                active_q      <= coef_nxt;
                mode_active_q <= mode_nxt;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++)
            prod_d[k] = PW'($signed({1'b0, pix_win[k*DW +: DW]})) * PW'(coef_eff[k]);
        for (int r = 0; r < 3; r++)
            row_d[r] = AW'(prod_q[3*r]) + AW'(prod_q[3*r+1]) + AW'(prod_q[3*r+2]);
        sum = row_q[0] + row_q[1] + row_q[2];
    end

    conv_round_sat #(
        .DW    (DW),
        .AW    (AW),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .sum    (sum),
        .centre (ctr2_q),
        .mode   (mode2_q),
        .res    (res_d),
        .sat    (sat_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++)
                prod_q[k] <= '0;
            for (int r = 0; r < 3; r++)
                row_q[r] <= '0;
            ctr1_q    <= '0;
            ctr2_q    <= '0;
            mode1_q   <= '0;
            mode2_q   <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (clken) begin
            prod_q    <= prod_d;
            ctr1_q    <= pix_win[4*DW +: DW];
            mode1_q   <= mode_eff;
            v1_q      <= in_valid;
            row_q     <= row_d;
            ctr2_q    <= ctr1_q;
            mode2_q   <= mode1_q;
            v2_q      <= v1_q;
            out_valid <= v2_q;
            if (v2_q) begin
                out      <= res_d;
                sat_flag <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_prog.sv
// Directed bench for conv3x3_prog: hand-computed results for defaults, modes,
// coefficient commit timing, clock-enable stall and reset flush.
module tb_conv3x3_prog;

    localparam int DW = 8;
    localparam int WW = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             clken;
    logic             sof;
    logic             in_valid;
    logic [9*DW-1:0]  pix_win;
    logic             cfg_wr;
    logic [9*WW-1:0]  cfg_coef;
    logic [1:0]       cfg_mode;
    logic [DW-1:0]    out;
    logic             out_valid;
    logic             sat_flag;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conv3x3_prog #(
        .DW    (DW),
        .WW    (WW),
        .SHIFT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .sof       (sof),
        .in_valid  (in_valid),
        .pix_win   (pix_win),
        .cfg_wr    (cfg_wr),
        .cfg_coef  (cfg_coef),
        .cfg_mode  (cfg_mode),
        .out       (out),
        .out_valid (out_valid),
        .sat_flag  (sat_flag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9*DW-1:0] win(input int cor, input int edg, input int ctr);
        logic [9*DW-1:0] w;
        for (int k = 0; k < 9; k++)
            w[k*DW +: DW] = DW'((k == 4) ? ctr : ((k % 2) == 1) ? edg : cor);
        return w;
    endfunction

    function automatic logic [9*WW-1:0] coefs(input int cor, input int edg, input int ctr);
        logic [9*WW-1:0] c;
        for (int k = 0; k < 9; k++)
            c[k*WW +: WW] = WW'((k == 4) ? ctr : ((k % 2) == 1) ? edg : cor);
        return c;
    endfunction

    task automatic beat(input string tag, input logic [9*DW-1:0] w,
                        input int exp_out, input int exp_sat);
        int n;
        pix_win  = w;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            step;
            n++;
        end
        chk({tag, "_vld"}, 32'(out_valid), 1);
        chk({tag, "_lat"}, n, 3);
        chk({tag, "_out"}, 32'(out), exp_out);
        chk({tag, "_sat"}, 32'(sat_flag), exp_sat);
    endtask

    task automatic cfg(input logic [9*WW-1:0] c, input logic [1:0] m, input bit do_sof);
        cfg_wr   = 1'b1;
        cfg_coef = c;
        cfg_mode = m;
        step;
        cfg_wr = 1'b0;
        if (do_sof) begin
            sof = 1'b1;
            step;
            sof = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9*WW-1:0] def_c;
        bit              seen;
        def_c    = coefs(-1, 2, 4);
        rst      = 1'b1;
        clken    = 1'b1;
        sof      = 1'b0;
        in_valid = 1'b0;
        cfg_wr   = 1'b0;
        pix_win  = '0;
        cfg_coef = '0;
        cfg_mode = 2'b00;
        step;
        step;
        chk("rst_out", 32'(out), 0);
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_sat", 32'(sat_flag), 0);
        rst = 1'b0;
        step;

        beat("flat", win(100, 100, 100), 100, 0);
        beat("impulse", win(0, 0, 255), 128, 0);
        beat("neg_clamp", win(255, 0, 0), 0, 1);

        cfg(def_c, 2'b10, 1'b1);
        beat("neg_abs", win(255, 0, 0), 127, 0);

        cfg(def_c, 2'b01, 1'b1);
        beat("sat_clamp", win(0, 255, 255), 255, 1);

        cfg(def_c, 2'b00, 1'b1);
        beat("bypass", win(0, 255, 255), 255, 0);
        beat("bypass77", win(0, 0, 77), 77, 0);

        // New coefficients written mid-frame must wait for sof
        cfg(def_c, 2'b01, 1'b1);
        cfg(coefs(0, 0, 1), 2'b01, 1'b0);
        beat("pre_commit", win(0, 0, 255), 128, 0);
        sof = 1'b1;
        step;
        sof = 1'b0;
        beat("post_commit", win(0, 0, 77), 10, 0);

        cfg_wr   = 1'b1;
        cfg_coef = def_c;
        cfg_mode = 2'b01;
        sof      = 1'b1;
        step;
        cfg_wr = 1'b0;
        sof    = 1'b0;
        beat("same_cycle", win(0, 0, 255), 128, 0);

        // Three back-to-back beats, then stall with junk on the inputs
        in_valid = 1'b1;
        pix_win  = win(100, 100, 100);
        step;
        pix_win  = win(0, 0, 255);
        step;
        pix_win  = win(0, 0, 77);
        step;
        clken   = 1'b0;
        pix_win = win(0, 255, 255);
        for (int i = 0; i < 5; i++) begin
            step;
            chk("stall_out", 32'(out), 100);
            chk("stall_vld", 32'(out_valid), 1);
        end
        clken    = 1'b1;
        in_valid = 1'b0;
        step;
        chk("resume1_out", 32'(out), 128);
        chk("resume1_vld", 32'(out_valid), 1);
        step;
        chk("resume2_out", 32'(out), 39);
        chk("resume2_vld", 32'(out_valid), 1);
        step;
        chk("resume3_vld", 32'(out_valid), 0);
        chk("resume3_hold", 32'(out), 39);

        in_valid = 1'b1;
        pix_win  = win(100, 100, 100);
        step;
        step;
        in_valid = 1'b0;
        rst      = 1'b1;
        step;
        rst = 1'b0;
        chk("flush_out", 32'(out), 0);
        chk("flush_vld", 32'(out_valid), 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step;
            if (out_valid)
                seen = 1'b1;
        end
        chk("flush_none", 32'(seen), 0);
        chk("flush_out_end", 32'(out), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
